// File: rtl/mtm_alu_pkg.sv
// mtm_alu_pkg: shared types, constants and CRC-4 step for the mtm_Alu serial link
package mtm_alu_pkg;
    localparam int DATA_PKTS = 8;
    localparam int PKT_W = 11;
    typedef enum logic [2:0] {OP_AND = 3'b000, OP_OR = 3'b001, OP_ADD = 3'b100, OP_SUB = 3'b101} operation_t;
    typedef bit [PKT_W-1:0] packet_t;
    typedef enum logic [2:0] {ERR_NONE = 3'b000, ERR_OP = 3'b001, ERR_CRC = 3'b010, ERR_DATA = 3'b100} err_t;
    localparam logic PKT_DATA = 1'b0;
    localparam logic PKT_CMD = 1'b1;

    // One MSB-first step of CRC-4, polynomial x^4+x+1
    function automatic logic [3:0] crc4_next(input logic [3:0] crc, input logic b);
        logic fb;
        fb = crc[3] ^ b;
        return {crc[2], crc[1], crc[0] ^ fb, fb};
    endfunction

    function automatic logic op_ok(input logic [2:0] op);
        return op inside {OP_AND, OP_OR, OP_ADD, OP_SUB};
    endfunction
endpackage

// File: rtl/mtm_alu_packet_rx.sv
// mtm_alu_packet_rx: bit-level receiver turning the sin line into 11-bit packets
module mtm_alu_packet_rx
    import mtm_alu_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       i_sin,
    output logic       o_pkt_valid,
    output logic       o_pkt_type,
    output logic [7:0] o_pkt_payload,
    output logic       o_pkt_frame_err
);
    typedef enum logic [1:0] {IDLE, SHIFT, PKT_END} state_t;

    state_t     r_state;
    logic [3:0] r_bit_cnt;
    logic [9:0] r_shift;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state         <= IDLE;
            r_bit_cnt       <= '0;
            r_shift         <= '0;
            o_pkt_valid     <= 1'b0;
            o_pkt_type      <= 1'b0;
            o_pkt_payload   <= '0;
            o_pkt_frame_err <= 1'b0;
        end else begin
            o_pkt_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (!i_sin) begin
                        r_state   <= SHIFT;
                        r_bit_cnt <= 4'(PKT_W - 2);
                    end
                end
                SHIFT: begin
                    r_shift   <= {r_shift[8:0], i_sin};
                    r_bit_cnt <= r_bit_cnt - 4'd1;
                    if (r_bit_cnt == 4'd0) r_state <= PKT_END;
                end
                PKT_END: begin
                    o_pkt_valid     <= 1'b1;
                    o_pkt_type      <= r_shift[9];
                    o_pkt_payload   <= r_shift[8:1];
                    o_pkt_frame_err <= !r_shift[0];
                    // The sample taken here may already be the next start bit
                    r_state         <= i_sin ? IDLE : SHIFT;
                    r_bit_cnt       <= 4'(PKT_W - 2);
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: rtl/mtm_alu_deserializer.sv
// mtm_alu_deserializer: assembles DATA/CMD packets into {A, B, op} or an error code
// with a valid/ready output register that drops new results while one is pending.
module mtm_alu_deserializer
    import mtm_alu_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        sin,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_A,
    output logic [31:0] out_B,
    output logic [2:0]  out_op,
    output logic [2:0]  out_err,
    output logic        overflow
);
    logic        w_pkt_valid;
    logic        w_pkt_type;
    logic        w_frame_err;
    logic [7:0]  w_payload;
    logic [3:0]  w_crc_data;
    logic [3:0]  w_crc_cmd;
    logic        w_done;
    logic        w_ok;
    logic [2:0]  w_err;
    logic [3:0]  r_data_cnt;
    logic        r_err_data;
    logic [3:0]  r_crc;
    logic [63:0] r_ops;

    mtm_alu_packet_rx u_rx (
        .clk             (clk),
        .rst             (rst),
        .i_sin           (sin),
        .o_pkt_valid     (w_pkt_valid),
        .o_pkt_type      (w_pkt_type),
        .o_pkt_payload   (w_payload),
        .o_pkt_frame_err (w_frame_err)
    );

    always_comb begin
        w_crc_data = r_crc;
        for (int i = 7; i >= 0; i--) w_crc_data = crc4_next(w_crc_data, w_payload[i]);
        w_crc_cmd = crc4_next(r_crc, 1'b1);
        for (int i = 6; i >= 4; i--) w_crc_cmd = crc4_next(w_crc_cmd, w_payload[i]);
    end

    assign w_done = w_pkt_valid && (w_frame_err || w_pkt_type == PKT_CMD);
    assign w_err  = (w_frame_err || r_err_data || r_data_cnt != 4'(DATA_PKTS)) ? ERR_DATA :
                    (w_crc_cmd != w_payload[3:0])                            ? ERR_CRC  :
                    !op_ok(w_payload[6:4])                                   ? ERR_OP   : ERR_NONE;
    assign w_ok   = (w_err == ERR_NONE);

    always_ff @(posedge clk) begin
        if (rst || w_done) begin
            r_data_cnt <= '0;
            r_err_data <= 1'b0;
            r_crc      <= '0;
            r_ops      <= '0;
        end else if (w_pkt_valid) begin
            r_ops      <= {r_ops[55:0], w_payload};
            r_crc      <= w_crc_data;
            r_data_cnt <= (r_data_cnt == 4'(DATA_PKTS + 1)) ? r_data_cnt : r_data_cnt + 4'd1;
            r_err_data <= r_err_data || (r_data_cnt == 4'(DATA_PKTS));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_A     <= '0;
            out_B     <= '0;
            out_op    <= '0;
            out_err   <= '0;
            overflow  <= 1'b0;
        end else begin
            overflow <= 1'b0;
            if (out_valid && out_ready) out_valid <= 1'b0;
            if (w_done) begin
                if (out_valid && !out_ready) begin
                    overflow <= 1'b1;
                end else begin
                    out_valid <= 1'b1;
                    out_err   <= w_err;
                    out_B     <= w_ok ? r_ops[63:32] : 32'd0;
                    out_A     <= w_ok ? r_ops[31:0] : 32'd0;
                    out_op    <= w_ok ? w_payload[6:4] : 3'b000;
                end
            end
        end
    end
endmodule

// File: tb/tb_mtm_alu_deserializer.sv
// tb_mtm_alu_deserializer: directed frames with a result scoreboard
module tb_mtm_alu_deserializer;
    logic        clk = 1'b0;
    logic        rst;
    logic        sin;
    logic        out_ready;
    logic        out_valid;
    logic        overflow;
    logic [31:0] out_A;
    logic [31:0] out_B;
    logic [2:0]  out_op;
    logic [2:0]  out_err;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  op;
        logic [2:0]  err;
    } res_t;

    res_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   ovf_cnt = 0;

    always #5 clk = ~clk;

    mtm_alu_deserializer dut (
        .clk       (clk),
        .rst       (rst),
        .sin       (sin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_A     (out_A),
        .out_B     (out_B),
        .out_op    (out_op),
        .out_err   (out_err),
        .overflow  (overflow)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference CRC by polynomial long division of msg*x^4 by x^4+x+1
    function automatic logic [3:0] crc_ref(input logic [75:0] msg, input int nbits);
        logic [79:0] r;
        r = {msg, 4'b0};
        for (int i = nbits + 3; i >= 4; i--)
            if (r[i]) r[i -: 5] = r[i -: 5] ^ 5'b10011;
        return r[3:0];
    endfunction

    always @(negedge clk) begin
        if (overflow === 1'b1) ovf_cnt++;
        if (rst === 1'b0 && out_valid === 1'b1 && out_ready === 1'b1) begin
            res_t e;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_result: got A=%0h B=%0h op=%0h err=%0h expected none", out_A, out_B, out_op, out_err);
            end else begin
                e = exp_q.pop_front();
                check("out_A", out_A, e.a);
                check("out_B", out_B, e.b);
                check("out_op", 32'(out_op), 32'(e.op));
                check("out_err", 32'(out_err), 32'(e.err));
            end
        end
    end

    task automatic idle(input int n);
        sin = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_pkt(input logic typ, input logic [7:0] pl, input logic stop);
        logic [10:0] p;
        p = {1'b0, typ, pl, stop};
        for (int i = 10; i >= 0; i--) begin
            sin = p[i];
            @(negedge clk);
        end
    endtask

    task automatic send_frame(input logic [71:0] d, input int n, input logic [2:0] op,
                              input logic [3:0] cxor, input logic push, input logic [2:0] err);
        logic [75:0] msg;
        res_t        e;
        msg = ({4'b0, d} << 4) | {72'b0, 1'b1, op};
        if (push) begin
            e.a   = (err == 3'b000) ? d[31:0] : 32'd0;
            e.b   = (err == 3'b000) ? d[63:32] : 32'd0;
            e.op  = (err == 3'b000) ? op : 3'b000;
            e.err = err;
            exp_q.push_back(e);
        end
        for (int i = n - 1; i >= 0; i--) send_pkt(1'b0, d[8*i +: 8], 1'b1);
        send_pkt(1'b1, {1'b0, op, crc_ref(msg, 8*n + 4) ^ cxor}, 1'b1);
    endtask

    initial begin
        logic [63:0] d1;
        rst = 1'b1;
        sin = 1'b1;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_A", out_A, 32'd0);
        check("rst_B", out_B, 32'd0);
        check("rst_op", 32'(out_op), 32'd0);
        check("rst_err", 32'(out_err), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        rst = 1'b0;
        idle(2);

        // A=10, B=20, ADD, hand-computed CRC 4'b0101
        d1 = {32'd20, 32'd10};
        exp_q.push_back('{32'd10, 32'd20, 3'b100, 3'b000});
        for (int i = 7; i >= 0; i--) send_pkt(1'b0, d1[8*i +: 8], 1'b1);
        send_pkt(1'b1, 8'h45, 1'b1);
        check("lat_E", 32'(out_valid), 32'd0);
        @(negedge clk);
        check("lat_E1", 32'(out_valid), 32'd0);
        @(negedge clk);
        check("lat_E2", 32'(out_valid), 32'd1);
        idle(3);

        send_frame({8'h0, 32'd20, 32'd10}, 8, 3'b100, 4'b0001, 1'b1, 3'b010);
        idle(4);
        send_frame({16'h0, 56'h11223344556677}, 7, 3'b000, 4'b0000, 1'b1, 3'b100);
        idle(4);
        send_frame(72'h99AABBCCDDEEFF0011, 9, 3'b001, 4'b0000, 1'b1, 3'b100);
        idle(4);
        send_frame({8'h0, 32'hDEADBEEF, 32'h12345678}, 8, 3'b010, 4'b0000, 1'b1, 3'b001);
        idle(4);
        send_frame({8'h0, 32'hDEADBEEF, 32'h12345678}, 8, 3'b011, 4'b1000, 1'b1, 3'b010);
        idle(4);
        send_frame({8'h0, 32'hCAFEF00D, 32'h0BADC0DE}, 8, 3'b101, 4'b0000, 1'b1, 3'b000);
        idle(4);

        // Back-to-back frames while the consumer stalls
        out_ready = 1'b0;
        send_frame({8'h0, 32'd7, 32'd3}, 8, 3'b000, 4'b0000, 1'b1, 3'b000);
        send_frame({8'h0, 32'd1, 32'd2}, 8, 3'b001, 4'b0000, 1'b0, 3'b000);
        idle(4);
        check("ovf_count", 32'(ovf_cnt), 32'd1);
        check("held_valid", 32'(out_valid), 32'd1);
        check("held_A", out_A, 32'd3);
        @(posedge clk);
        #1 out_ready = 1'b1;
        idle(3);
        check("valid_dropped", 32'(out_valid), 32'd0);

        // Reset in the middle of DATA packet 4
        for (int i = 0; i < 3; i++) send_pkt(1'b0, 8'h55, 1'b1);
        sin = 1'b0; @(negedge clk);
        sin = 1'b0; @(negedge clk);
        sin = 1'b1; @(negedge clk);
        sin = 1'b0; @(negedge clk);
        rst = 1'b1;
        sin = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        idle(2);
        send_frame({8'h0, 32'd100, 32'd55}, 8, 3'b100, 4'b0000, 1'b1, 3'b000);
        idle(4);

        // Framing error on a DATA packet, then recovery
        exp_q.push_back('{32'd0, 32'd0, 3'b000, 3'b100});
        send_pkt(1'b0, 8'hA5, 1'b0);
        idle(4);
        send_frame({8'h0, 32'h80000001, 32'hFFFFFFFF}, 8, 3'b001, 4'b0000, 1'b1, 3'b000);
        idle(6);

        check("queue_empty", 32'(exp_q.size()), 32'd0);
        check("ovf_total", 32'(ovf_cnt), 32'd1);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
